// File: rtl/step_timer_pkg.sv
// Shared types and defaults for the stream step timer.
package step_timer_pkg;

  localparam int CNTR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/axis_step_timer_if.sv
// Gating handshake between the step timer and the downstream stepper input.
interface axis_step_timer_if;

  logic s_axis_tvalid;
  logic trg_flag;

  // The timer observes valid and drives trg_flag into the stepper's tready.
  modport slave  (input  s_axis_tvalid, output trg_flag);
  modport master (output s_axis_tvalid, input  trg_flag);

endinterface

// File: rtl/axis_step_timer.sv
// Step timer: asserts trg_flag once per step until a beat is accepted,
// spacing beats by a programmed period for a programmed (or unlimited) count.
module axis_step_timer
  import step_timer_pkg::*;
#(
  parameter int CNTR_WIDTH = CNTR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  run_flag,
  input  logic [CNTR_WIDTH-1:0] cfg_period,
  input  logic [CNTR_WIDTH-1:0] cfg_steps,
  axis_step_timer_if.slave      axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNTR_WIDTH-1:0] sts_steps
);

  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  state_t                state;
  logic                  run_q;
  logic                  trg_q;
  logic [CNTR_WIDTH-1:0] cnt;
  logic [CNTR_WIDTH-1:0] period_q;
  logic [CNTR_WIDTH-1:0] steps_q;

  logic                  start;
  logic                  beat;
  logic [CNTR_WIDTH-1:0] p_eff;
  logic [CNTR_WIDTH-1:0] steps_inc;

  assign start     = run_flag & ~run_q;
  assign beat      = trg_q & axis.s_axis_tvalid;
  assign p_eff     = (cfg_period == '0) ? ONE : cfg_period;
  assign steps_inc = sts_steps + ONE;

  assign axis.trg_flag = trg_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      run_q     <= 1'b0;
      trg_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sts_steps <= '0;
      cnt       <= '0;
      period_q  <= '0;
      steps_q   <= '0;
    end else begin
      run_q <= run_flag;
      case (state)
        ST_IDLE: begin
          if (start) begin
            period_q  <= p_eff;
            steps_q   <= cfg_steps;
            sts_steps <= '0;
            busy      <= 1'b1;
            if (p_eff == ONE) begin
              state <= ST_FIRE;
              trg_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= p_eff - ONE;
            end
          end
        end

        ST_WAIT: begin
          cnt <= cnt - ONE;
          if (!run_flag) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == ONE) begin
            state <= ST_FIRE;
            trg_q <= 1'b1;
          end
        end

        ST_FIRE: begin
          // A beat in the abort cycle is still counted; abort wins over DONE.
          if (beat) sts_steps <= steps_inc;
          if (!run_flag) begin
            state <= ST_IDLE;
            trg_q <= 1'b0;
            busy  <= 1'b0;
          end else if (beat) begin
            if (steps_q != '0 && steps_inc == steps_q) begin
              state <= ST_DONE;
              trg_q <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (period_q != ONE) begin
              state <= ST_WAIT;
              trg_q <= 1'b0;
              cnt   <= period_q - ONE;
            end
          end
        end

        ST_DONE: begin
          if (!run_flag) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          trg_q <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_step_timer.sv
// Directed bench for axis_step_timer: expected beat cycles go into a scoreboard
// queue, and a monitor pops and compares on every observed beat.
module tb_axis_step_timer;

  localparam int W = 32;

  logic         aclk;
  logic         aresetn;
  logic         run_flag;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_steps;
  logic         busy;
  logic         done;
  logic [W-1:0] sts_steps;

  axis_step_timer_if ifc ();

  axis_step_timer #(.CNTR_WIDTH(W)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .run_flag   (run_flag),
    .cfg_period (cfg_period),
    .cfg_steps  (cfg_steps),
    .axis       (ifc.slave),
    .busy       (busy),
    .done       (done),
    .sts_steps  (sts_steps)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int s;
  int exp_q[$];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted beat must match the next expected beat cycle.
  always @(negedge aclk) begin
    if (aresetn && ifc.trg_flag && ifc.s_axis_tvalid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: beat at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          n_fail++;
          $display("FAIL beat_cycle: beat at cycle %0d expected at %0d", cyc, e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] p, input logic [W-1:0] n);
    cfg_period = p;
    cfg_steps  = n;
    run_flag   = 1'b1;
    s          = cyc;
  endtask

  task automatic stop_run();
    run_flag = 1'b0;
    cycles(2);
  endtask

  initial begin
    aresetn             = 1'b0;
    run_flag            = 1'b0;
    cfg_period          = '0;
    cfg_steps           = '0;
    ifc.s_axis_tvalid   = 1'b0;
    cycles(3);
    check("reset_trg", W'(ifc.trg_flag), 0);
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_steps", sts_steps, 0);
    aresetn = 1'b1;
    cycles(2);

    // 1: P=4, N=3, constant valid
    ifc.s_axis_tvalid = 1'b1;
    start_run(4, 3);
    for (int i = 1; i <= 3; i++) exp_q.push_back(s + 4 * i);
    cycles(14);
    check("t1_done", W'(done), 1);
    check("t1_busy", W'(busy), 0);
    check("t1_trg", W'(ifc.trg_flag), 0);
    check("t1_steps", sts_steps, 3);
    stop_run();
    check("t1_done_clr", W'(done), 0);

    // 2: P=1, N=5, back-to-back beats
    start_run(1, 5);
    for (int i = 1; i <= 5; i++) exp_q.push_back(s + i);
    cycles(7);
    check("t2_done", W'(done), 1);
    check("t2_steps", sts_steps, 5);
    stop_run();

    // 3: P=3, N=2, valid stalled for 6 cycles after first trg_flag
    ifc.s_axis_tvalid = 1'b0;
    start_run(3, 2);
    exp_q.push_back(s + 9);
    exp_q.push_back(s + 12);
    cycles(2);
    check("t3_wait_trg", W'(ifc.trg_flag), 0);
    check("t3_wait_busy", W'(busy), 1);
    cycles(6);
    check("t3_stall_trg", W'(ifc.trg_flag), 1);
    cycles(1);
    ifc.s_axis_tvalid = 1'b1;
    cycles(5);
    check("t3_done", W'(done), 1);
    check("t3_steps", sts_steps, 2);
    stop_run();

    // 4: P=2, continuous, aborted after 20 cycles
    start_run(2, 0);
    for (int i = 1; i <= 10; i++) exp_q.push_back(s + 2 * i);
    cycles(20);
    run_flag = 1'b0;
    cycles(1);
    check("t4_busy", W'(busy), 0);
    check("t4_trg", W'(ifc.trg_flag), 0);
    check("t4_done", W'(done), 0);
    check("t4_steps", sts_steps, 10);
    cycles(3);
    check("t4_steps_hold", sts_steps, 10);

    // 5: final beat coincides with run_flag low
    start_run(2, 3);
    for (int i = 1; i <= 3; i++) exp_q.push_back(s + 2 * i);
    cycles(6);
    run_flag = 1'b0;
    cycles(1);
    check("t5_steps", sts_steps, 3);
    check("t5_done", W'(done), 0);
    check("t5_busy", W'(busy), 0);
    cycles(3);
    check("t5_no_restart", W'(busy), 0);

    // 6: cfg_period=0 acts as P=1; asynchronous reset mid-FIRE
    start_run(0, 0);
    exp_q.push_back(s + 1);
    exp_q.push_back(s + 2);
    cycles(3);
    aresetn  = 1'b0;
    run_flag = 1'b0;
    #1;
    check("t6_rst_trg", W'(ifc.trg_flag), 0);
    check("t6_rst_busy", W'(busy), 0);
    check("t6_rst_steps", sts_steps, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cycles(3);
    check("t6_idle_busy", W'(busy), 0);
    check("beats_pending", W'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
